ipad_win_ctl: RTL

- Next-generation input-pad controller for one PE.
- Manages a circular input scratchpad of parametrised depth holding the sliding convolution window of Pch channels × R pixels.
- Generates pad write addresses for incoming pixels and read addresses for the MAC datapath.
- Overlaps refill with window reads: new pixels for the next window are written while the current window is being read, and only the U×Pch stride entries are replaced per window.

---
 rtl/ipad_win_ctl_pkg.sv | 49 ++++
 rtl/ipad_win_ctl_if.sv | 32 +++
 rtl/ipad_circ_ptr.sv | 24 ++
 rtl/ipad_win_ctl.sv | 136 +++++++++++++
 4 files changed

// File: rtl/ipad_win_ctl_pkg.sv
// Shared types and sizing for the input-pad window controller.
// The pad pointer wrap helper lives here so the top and the pointer sub-module agree on it.
package ipad_win_ctl_pkg;

    localparam int IPadSize = 12;
    localparam int CfgWd    = 6;
    localparam int TileWd   = 10;
    localparam int AddrWd   = $clog2(IPadSize);
    localparam int CntWd    = AddrWd + 1;
    localparam int MulWd    = 2 * CfgWd;
    localparam int TotWd    = 2 * CfgWd + TileWd + 1;

    localparam logic [CntWd-1:0] PadDepth = IPadSize[CntWd-1:0];
    localparam logic [CntWd:0]   PadLimit = IPadSize[CntWd:0];

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        INIT = 4'd1,
        LOOP = 4'd2,
        POP  = 4'd3,
        DONE = 4'd4
    } ipad_state_e;

    typedef struct packed {
        logic [CfgWd-1:0]  pch;
        logic [CfgWd-1:0]  r;
        logic [CfgWd-1:0]  u;
        logic [TileWd-1:0] tw;
    } ipad_win_conf_t;

    typedef struct packed {
        logic [AddrWd-1:0] raddr;
        logic [AddrWd-1:0] waddr;
        logic              read;
        logic              write;
    } ipad_addr_t;

    // Both operands are below IPadSize (offset at most IPadSize), so one conditional subtract wraps.
    function automatic logic [AddrWd-1:0] wrap_add(input logic [AddrWd-1:0] base,
                                                   input logic [CntWd-1:0]  offs);
        logic [CntWd:0] sum;
        sum = {2'b00, base} + {1'b0, offs};
        if (sum >= PadLimit) begin
            sum = sum - PadLimit;
        end
        return sum[AddrWd-1:0];
    endfunction

endpackage

// File: rtl/ipad_win_ctl_if.sv
// Control/config and pad-address bundle between the PE issue logic and the input-pad controller.
interface ipad_win_ctl_if;

    logic                                   i_start;
    logic [ipad_win_ctl_pkg::CfgWd-1:0]     i_pch;
    logic [ipad_win_ctl_pkg::CfgWd-1:0]     i_r;
    logic [ipad_win_ctl_pkg::CfgWd-1:0]     i_u;
    logic [ipad_win_ctl_pkg::TileWd-1:0]    i_tw;
    logic                                   i_stall;
    logic                                   i_dval;
    logic                                   o_drdy;
    logic                                   o_wr;
    logic [ipad_win_ctl_pkg::AddrWd-1:0]    o_waddr;
    logic                                   o_rd;
    logic [ipad_win_ctl_pkg::AddrWd-1:0]    o_raddr;
    logic                                   o_wlast;
    logic                                   o_busy;
    logic                                   o_done;
    logic                                   o_cerr;
    logic [3:0]                             o_state;

    modport master (
        output i_start, i_pch, i_r, i_u, i_tw, i_stall, i_dval,
        input  o_drdy, o_wr, o_waddr, o_rd, o_raddr, o_wlast, o_busy, o_done, o_cerr, o_state
    );

    modport slave (
        input  i_start, i_pch, i_r, i_u, i_tw, i_stall, i_dval,
        output o_drdy, o_wr, o_waddr, o_rd, o_raddr, o_wlast, o_busy, o_done, o_cerr, o_state
    );

endinterface

// File: rtl/ipad_circ_ptr.sv
// Modulo-IPadSize pointer into the circular input pad; advances by one or by a stride.
module ipad_circ_ptr
    import ipad_win_ctl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    input  logic              inc_step,
    input  logic [CntWd-1:0]  step,
    output logic [AddrWd-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            ptr <= '0;
        end else if (inc_step) begin
            ptr <= wrap_add(ptr, step);
        end else if (inc) begin
            ptr <= wrap_add(ptr, CntWd'(1));
        end
    end

endmodule

// File: rtl/ipad_win_ctl.sv
// Input-pad window controller: refills the circular pad while the MAC reads the current window,
// replacing only the stride entries between consecutive windows.
module ipad_win_ctl
    import ipad_win_ctl_pkg::*;
(
    input  logic           i_clk,
    input  logic           i_rst,
    ipad_win_ctl_if.slave  bus
);

    ipad_state_e      state, state_next;
    ipad_win_conf_t   conf;
    ipad_addr_t       pad;
    logic [CntWd-1:0] win, step, count, idx;
    logic [TotWd-1:0] wtotal, written, wtotal_calc;
    logic [TileWd-1:0] win_cnt;
    logic [MulWd-1:0] area;
    logic [AddrWd-1:0] head, tail;
    logic cerr, illegal, running, drdy, wr, rd, last_rd;
    logic final_win, pop_adv, accept, init_ok, init_bad;

    always_comb begin
        area        = MulWd'(conf.pch) * MulWd'(conf.r);
        illegal     = (conf.pch == '0) || (conf.r == '0) || (conf.u == '0) || (conf.tw == '0) ||
                      (conf.u > conf.r) || (area > MulWd'(IPadSize));
        wtotal_calc = TotWd'(conf.pch) *
                      (TotWd'(conf.r) + (TotWd'(conf.tw) - TotWd'(1)) * TotWd'(conf.u));
        running     = (state == LOOP) || (state == POP);
        drdy        = running && !bus.i_stall && (count < PadDepth) && (written < wtotal);
        wr          = bus.i_dval && drdy;
        rd          = (state == LOOP) && !bus.i_stall && (idx < count);
        last_rd     = rd && (idx == win - CntWd'(1));
        final_win   = (win_cnt == conf.tw - TileWd'(1));
        pop_adv     = (state == POP) && !bus.i_stall && !final_win;
        accept      = (state == IDLE) && bus.i_start && !bus.i_stall;
        init_ok     = (state == INIT) && !bus.i_stall && !illegal;
        init_bad    = (state == INIT) && !bus.i_stall && illegal;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = INIT;
            INIT: if (init_bad) state_next = IDLE;
                  else if (init_ok) state_next = LOOP;
            LOOP: if (last_rd) state_next = POP;
            POP:  if (!bus.i_stall) state_next = final_win ? DONE : LOOP;
            DONE: if (!bus.i_stall) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            conf    <= '0;
            win     <= '0;
            step    <= '0;
            wtotal  <= '0;
            written <= '0;
            count   <= '0;
            idx     <= '0;
            win_cnt <= '0;
            cerr    <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                conf <= '{pch: bus.i_pch, r: bus.i_r, u: bus.i_u, tw: bus.i_tw};
                cerr <= 1'b0;
            end
            if (init_bad) begin
                cerr <= 1'b1;
            end
            // Legal config guarantees both products are at most IPadSize, so truncation is safe.
            if (init_ok) begin
                win     <= CntWd'(conf.pch * conf.r);
                step    <= CntWd'(conf.u * conf.pch);
                wtotal  <= wtotal_calc;
                written <= '0;
                count   <= '0;
                idx     <= '0;
                win_cnt <= '0;
            end else begin
                written <= written + TotWd'(wr);
                count   <= count + CntWd'(wr) - (pop_adv ? step : '0);
                if (last_rd) begin
                    idx <= '0;
                end else if (rd) begin
                    idx <= idx + CntWd'(1);
                end
                if (pop_adv) begin
                    win_cnt <= win_cnt + TileWd'(1);
                end
            end
        end
    end

    ipad_circ_ptr u_head (
        .clk      (i_clk),
        .rst      (i_rst),
        .clr      (init_ok),
        .inc      (1'b0),
        .inc_step (pop_adv),
        .step     (step),
        .ptr      (head)
    );

    ipad_circ_ptr u_tail (
        .clk      (i_clk),
        .rst      (i_rst),
        .clr      (init_ok),
        .inc      (wr),
        .inc_step (1'b0),
        .step     ('0),
        .ptr      (tail)
    );

    always_comb begin
        pad.raddr = wrap_add(head, idx);
        pad.waddr = tail;
        pad.read  = rd;
        pad.write = wr;
    end

    assign bus.o_drdy  = drdy;
    assign bus.o_wr    = pad.write;
    assign bus.o_waddr = pad.waddr;
    assign bus.o_rd    = pad.read;
    assign bus.o_raddr = pad.raddr;
    assign bus.o_wlast = last_rd;
    assign bus.o_busy  = (state != IDLE);
    assign bus.o_done  = (state == DONE) && !bus.i_stall;
    assign bus.o_cerr  = cerr;
    assign bus.o_state = state;

endmodule
